// File: rtl/popcount09_unary_tx.sv
// popcount09_unary_tx: expands a count into an N-beat unary frame with min(count,N) ones.
// Ports: cnt_i/cnt_valid_i/cnt_ready_o count in; bit_o/bit_valid_o/bit_last_o/bit_ready_i serial out;
// therm_o/sat_o registered thermometer code and clamp flag of the latest accepted count.
// Build option POPCOUNT09_UNARY_SPREAD_EN spreads the ones evenly (Bresenham) instead of leading.
module popcount09_unary_tx #(
  parameter int N  = 9,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] cnt_i,
  input  logic          cnt_valid_i,
  output logic          cnt_ready_o,
  output logic          bit_o,
  output logic          bit_valid_o,
  output logic          bit_last_o,
  input  logic          bit_ready_i,
  output logic [N-1:0]  therm_o,
  output logic          sat_o
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt_q, clamp;
  logic [N-1:0] therm_n;
  logic last, xfer, accept;
  assign last        = idx == IW'(N - 1);
  assign xfer        = state == SHIFT && bit_ready_i;
  // ready also opens on the last-beat transfer so frames can run back to back
  assign cnt_ready_o = state == IDLE || (xfer && last);
  assign accept      = cnt_valid_i && cnt_ready_o;
  assign clamp       = cnt_i > CW'(N) ? CW'(N) : cnt_i;
  assign bit_valid_o = state == SHIFT;
  assign bit_last_o  = bit_valid_o && last;
  always_comb begin
    therm_n = '0;
    for (int k = 0; k < N; k++) therm_n[k] = k < int'(clamp);
  end
  always_comb begin
    state_n = accept ? SHIFT : (xfer && last) ? IDLE : state;
    idx_n   = (accept || (xfer && last)) ? '0 : xfer ? IW'(idx + 1'b1) : idx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt_q   <= '0;
      therm_o <= '0;
      sat_o   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (accept) begin
        cnt_q   <= clamp;
        therm_o <= therm_n;
        sat_o   <= cnt_i > CW'(N);
      end
    end
`ifdef POPCOUNT09_UNARY_SPREAD_EN
  localparam int AW = $clog2(2 * N);
  logic [AW-1:0] acc;
  logic [AW:0] sum;
  logic hit;
  // acc stays below N, so acc+cnt_q crossing N marks where the next one falls
  assign sum   = (AW + 1)'(acc) + (AW + 1)'(cnt_q);
  assign hit   = sum >= (AW + 1)'(N);
  assign bit_o = bit_valid_o && hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (accept) acc <= '0;
    else if (xfer) acc <= AW'(hit ? sum - (AW + 1)'(N) : sum);
`else
  assign bit_o = bit_valid_o && (int'(idx) < int'(cnt_q));
`endif
endmodule

// File: tb/tb_popcount09_unary_tx.sv
// tb_popcount09_unary_tx: directed frames checked against a frame-queue model plus literal frame patterns.
module tb_popcount09_unary_tx;
  localparam int N = 9, CW = 4;
  logic clk = 0, rst_n = 0;
  logic [CW-1:0] cnt_i = '0;
  logic cnt_valid_i = 0, bit_ready_i = 1;
  logic cnt_ready_o, bit_o, bit_valid_o, bit_last_o, sat_o;
  logic [N-1:0] therm_o;

  popcount09_unary_tx #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_i(cnt_i), .cnt_valid_i(cnt_valid_i),
    .cnt_ready_o(cnt_ready_o), .bit_o(bit_o), .bit_valid_o(bit_valid_o),
    .bit_last_o(bit_last_o), .bit_ready_i(bit_ready_i), .therm_o(therm_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a queue of the beats still owed downstream, plus the latest therm/sat.
  bit mq[$];
  logic [N-1:0] m_therm = '0;
  logic m_sat = 0;
  bit m_rdy;
  int m_c;

  function automatic bit frame_bit(input int c, input int i);
`ifdef POPCOUNT09_UNARY_SPREAD_EN
    return ((i + 1) * c) / N > (i * c) / N;
`else
    return i < c;
`endif
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mq.delete();
      m_therm = '0;
      m_sat = 0;
    end else begin
      m_rdy = mq.size() == 0 || (mq.size() == 1 && bit_ready_i);
      if (mq.size() > 0 && bit_ready_i) void'(mq.pop_front());
      if (m_rdy && cnt_valid_i) begin
        m_c = int'(cnt_i) > N ? N : int'(cnt_i);
        for (int i = 0; i < N; i++) mq.push_back(frame_bit(m_c, i));
        m_therm = '0;
        for (int k = 0; k < m_c; k++) m_therm[k] = 1'b1;
        m_sat = int'(cnt_i) > N;
      end
    end

  always @(negedge clk)
    if (rst_n) begin
      check("valid", 32'(bit_valid_o), 32'(mq.size() > 0));
      check("ready", 32'(cnt_ready_o), 32'(mq.size() == 0 || (mq.size() == 1 && bit_ready_i)));
      check("therm", 32'(therm_o), 32'(m_therm));
      check("sat", 32'(sat_o), 32'(m_sat));
      if (mq.size() > 0) begin
        check("bit", 32'(bit_o), 32'(mq[0]));
        check("last", 32'(bit_last_o), 32'(mq.size() == 1));
      end
    end

  // Log of transferred beats, newest in bit 0.
  logic [31:0] log_bits = '0;
  int n_beats = 0;
  always @(posedge clk)
    if (rst_n && bit_valid_o && bit_ready_i) begin
      log_bits <= {log_bits[30:0], bit_o};
      n_beats <= n_beats + 1;
    end

  task automatic send(input logic [CW-1:0] c);
    int t = 0;
    cnt_i = c;
    cnt_valid_i = 1;
    @(negedge clk);
    while (!cnt_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 32'(t < 50), 32'd1);
    @(posedge clk);
    #1 cnt_valid_i = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (mq.size() > 0 && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    check("drain_timeout", 32'(t < 100), 32'd1);
    @(posedge clk);
    #1;
  endtask

  int start;
  initial begin
    #1;
    check("rst_valid", 32'(bit_valid_o), 0);
    check("rst_bit", 32'(bit_o), 0);
    check("rst_last", 32'(bit_last_o), 0);
    check("rst_therm", 32'(therm_o), 0);
    check("rst_sat", 32'(sat_o), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
`ifndef POPCOUNT09_UNARY_SPREAD_EN
    send(4'd5);
    check("first_beat_latency", 32'(bit_valid_o), 1);
    drain();
    check("frame5", 32'(log_bits[8:0]), 32'h1F0);
    check("therm5", 32'(therm_o), 32'h01F);
    check("sat5", 32'(sat_o), 0);
    send(4'd13);
    drain();
    check("frame13", 32'(log_bits[8:0]), 32'h1FF);
    check("therm13", 32'(therm_o), 32'h1FF);
    check("sat13", 32'(sat_o), 1);
    send(4'd0);
    drain();
    check("frame0", 32'(log_bits[8:0]), 32'h000);
    check("therm0", 32'(therm_o), 32'h000);
    check("sat0", 32'(sat_o), 0);
    start = n_beats;
    send(4'd2);
    send(4'd7);
    drain();
    check("b2b_frames", 32'(log_bits[17:0]), 32'b110000000111111100);
    check("b2b_beats", 32'(n_beats - start), 32'd18);
`else
    send(4'd3);
    drain();
    check("spread3", 32'(log_bits[8:0]), 32'b001001001);
    send(4'd9);
    drain();
    check("spread9", 32'(log_bits[8:0]), 32'h1FF);
    send(4'd4);
    drain();
    check("spread4", 32'(log_bits[8:0]), 32'b001010101);
    check("spread_therm4", 32'(therm_o), 32'h00F);
    send(4'd15);
    drain();
    check("spread15", 32'(log_bits[8:0]), 32'h1FF);
    check("spread_sat15", 32'(sat_o), 1);
`endif
    // Back-pressure: ready pattern 1,0,0,1 repeating.
    start = n_beats;
    send(4'd4);
    for (int j = 0; j < 100 && mq.size() > 0; j++) begin
      bit_ready_i = (j % 4 == 0) || (j % 4 == 3);
      @(posedge clk);
      #1;
    end
    bit_ready_i = 1;
    check("bp_beats", 32'(n_beats - start), 32'd9);
    check("bp_ones", 32'($countones(log_bits[8:0])), 32'd4);
`ifndef POPCOUNT09_UNARY_SPREAD_EN
    check("bp_frame", 32'(log_bits[8:0]), 32'h1E0);
`endif
    // Reset in the middle of a cnt_i=9 frame.
    send(4'd9);
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("mid_rst_valid", 32'(bit_valid_o), 0);
    check("mid_rst_therm", 32'(therm_o), 0);
    check("mid_rst_sat", 32'(sat_o), 0);
    check("mid_rst_bit", 32'(bit_o), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    start = n_beats;
    send(4'd1);
    drain();
    check("post_rst_beats", 32'(n_beats - start), 32'd9);
`ifndef POPCOUNT09_UNARY_SPREAD_EN
    check("post_rst_frame", 32'(log_bits[8:0]), 32'h100);
`else
    check("post_rst_frame", 32'(log_bits[8:0]), 32'h001);
`endif
    check("post_rst_therm", 32'(therm_o), 32'h001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
